// File: rtl/mandelbrot_pkg.sv
// Shared types and constants for the Mandelbrot solver lane controller.
package mandelbrot_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ABS,
      ST_ITER,
      ST_CHECK,
      ST_DONE
   } state_t;

   localparam logic [1:0] DP_IDLE = 2'd0;
   localparam logic [1:0] DP_ABS  = 2'd1;
   localparam logic [1:0] DP_ITER = 2'd2;

   localparam int DEF_LIMB_INDEX_BITS = 6;
   localparam int DEF_ITER_BITS       = 16;

endpackage

// File: rtl/limb_sequencer.sv
// Walks the limb index 0..num_limbs-1 once per start pulse, LSB first.
module limb_sequencer #(
   parameter int LIMB_INDEX_BITS = 6
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   input  logic [LIMB_INDEX_BITS:0]   num_limbs,
   output logic [LIMB_INDEX_BITS-1:0] limb_ind,
   output logic                       first,
   output logic                       last,
   output logic                       done
);

   logic                       active;
   logic [LIMB_INDEX_BITS-1:0] idx;
   logic                       at_end;

   assign at_end   = ({1'b0, idx} == (num_limbs - 1'b1));
   assign limb_ind = idx;
   assign first    = active && (idx == '0);
   assign last     = active && at_end;
   assign done     = last;

   // Index counter; a start pulse restarts the walk even on the final limb of a pass.
   always_ff @(posedge clock) begin
      if (reset) begin
         active <= 1'b0;
         idx    <= '0;
      end else if (start) begin
         active <= 1'b1;
         idx    <= '0;
      end else if (active) begin
         if (at_end) begin
            active <= 1'b0;
            idx    <= '0;
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mandelbrot_solver_ctrl.sv
// Control FSM for one limb-serial Mandelbrot solver lane.
//   state | meaning
//   IDLE  | waiting for limb 0 of c; clears z and the iteration count on accept
//   LOAD  | accepting the remaining limbs of c
//   ABS   | one datapath pass computing |z|^2
//   ITER  | one datapath pass computing z <= z^2 + c
//   CHECK | single-cycle decision: diverged, limit reached, or iterate again
//   DONE  | result presented until res_rdy
module mandelbrot_solver_ctrl
   import mandelbrot_pkg::*;
#(
   parameter int LIMB_INDEX_BITS = DEF_LIMB_INDEX_BITS,
   parameter int MAX_LIMBS       = 32,
   parameter int ITER_BITS       = DEF_ITER_BITS
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       c_val,
   output logic                       c_rdy,
   input  logic                       c_last,
   input  logic [ITER_BITS-1:0]       max_iter,
   output logic [LIMB_INDEX_BITS-1:0] limb_ind,
   output logic                       cre_wr_en,
   output logic                       cim_wr_en,
   output logic                       z_clear,
   output logic [1:0]                 dp_op,
   output logic                       dp_first,
   output logic                       dp_last,
   input  logic                       diverged,
   output logic                       res_val,
   input  logic                       res_rdy,
   output logic [ITER_BITS-1:0]       res_count,
   output logic                       res_escaped
);

   state_t                     state, state_nxt;
   logic [LIMB_INDEX_BITS-1:0] load_idx;
   logic [LIMB_INDEX_BITS:0]   num_limbs;
   logic [ITER_BITS-1:0]       max_iter_q;
   logic [ITER_BITS-1:0]       iter_count;
   logic                       escaped_q;
   logic                       load_last;
   logic                       first_last;

   logic                       seq_start;
   logic [LIMB_INDEX_BITS-1:0] seq_idx;
   logic                       seq_first;
   logic                       seq_last;
   logic                       seq_done;

   // A beat at the top index ends the load even without c_last.
   assign load_last  = c_last || (load_idx == LIMB_INDEX_BITS'(MAX_LIMBS - 1));
   assign first_last = c_last || (MAX_LIMBS == 1);

   limb_sequencer #(
      .LIMB_INDEX_BITS(LIMB_INDEX_BITS)
   ) u_seq (
      .clock     (clock),
      .reset     (reset),
      .start     (seq_start),
      .num_limbs (num_limbs),
      .limb_ind  (seq_idx),
      .first     (seq_first),
      .last      (seq_last),
      .done      (seq_done)
   );

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next state, load handshake and pass start pulses.
   always_comb begin
      state_nxt = state;
      seq_start = 1'b0;
      c_rdy     = 1'b0;
      cre_wr_en = 1'b0;
      cim_wr_en = 1'b0;
      z_clear   = 1'b0;
      case (state)
         ST_IDLE: begin
            c_rdy = 1'b1;
            if (c_val) begin
               cre_wr_en = 1'b1;
               cim_wr_en = 1'b1;
               z_clear   = 1'b1;
               if (first_last) begin
                  if (max_iter == '0) begin
                     state_nxt = ST_DONE;
                  end else begin
                     state_nxt = ST_ABS;
                     seq_start = 1'b1;
                  end
               end else begin
                  state_nxt = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            c_rdy     = 1'b1;
            cre_wr_en = c_val;
            cim_wr_en = c_val;
            if (c_val && load_last) begin
               if (max_iter_q == '0) begin
                  state_nxt = ST_DONE;
               end else begin
                  state_nxt = ST_ABS;
                  seq_start = 1'b1;
               end
            end
         end
         ST_ABS: begin
            if (seq_done) begin
               state_nxt = ST_ITER;
               seq_start = 1'b1;
            end
         end
         ST_ITER: begin
            if (seq_done) state_nxt = ST_CHECK;
         end
         ST_CHECK: begin
            if (diverged || (iter_count == max_iter_q)) begin
               state_nxt = ST_DONE;
            end else begin
               state_nxt = ST_ABS;
               seq_start = 1'b1;
            end
         end
         ST_DONE: begin
            if (res_rdy) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Load index, operand length, limit, iteration count and escape flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         load_idx   <= '0;
         num_limbs  <= '0;
         max_iter_q <= '0;
         iter_count <= '0;
         escaped_q  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (c_val) begin
                  max_iter_q <= max_iter;
                  iter_count <= '0;
                  escaped_q  <= 1'b0;
                  load_idx   <= LIMB_INDEX_BITS'(1);
                  if (first_last) num_limbs <= (LIMB_INDEX_BITS+1)'(1);
               end
            end
            ST_LOAD: begin
               if (c_val) begin
                  load_idx <= load_idx + 1'b1;
                  if (load_last) num_limbs <= {1'b0, load_idx} + 1'b1;
               end
            end
            ST_ITER: begin
               if (seq_done) iter_count <= iter_count + 1'b1;
            end
            ST_CHECK: begin
               if (diverged) escaped_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Datapath-facing outputs decoded from registered state.
   always_comb begin
      limb_ind = '0;
      dp_op    = DP_IDLE;
      dp_first = 1'b0;
      dp_last  = 1'b0;
      case (state)
         ST_LOAD: limb_ind = load_idx;
         ST_ABS: begin
            limb_ind = seq_idx;
            dp_op    = DP_ABS;
            dp_first = seq_first;
            dp_last  = seq_last;
         end
         ST_ITER: begin
            limb_ind = seq_idx;
            dp_op    = DP_ITER;
            dp_first = seq_first;
            dp_last  = seq_last;
         end
         default: ;
      endcase
   end

   assign res_val     = (state == ST_DONE);
   assign res_count   = iter_count;
   assign res_escaped = escaped_q;

endmodule

// File: tb/tb_mandelbrot_solver_ctrl.sv
// Directed self-checking bench for mandelbrot_solver_ctrl (default parameters).
module tb_mandelbrot_solver_ctrl;

   localparam int LIB = 6;
   localparam int ML  = 32;
   localparam int IB  = 16;

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic           c_val = 1'b0;
   logic           c_rdy;
   logic           c_last = 1'b0;
   logic [IB-1:0]  max_iter = '0;
   logic [LIB-1:0] limb_ind;
   logic           cre_wr_en, cim_wr_en, z_clear;
   logic [1:0]     dp_op;
   logic           dp_first, dp_last;
   logic           diverged = 1'b0;
   logic           res_val;
   logic           res_rdy = 1'b0;
   logic [IB-1:0]  res_count;
   logic           res_escaped;

   int checks = 0;
   int errors = 0;

   mandelbrot_solver_ctrl #(
      .LIMB_INDEX_BITS(LIB),
      .MAX_LIMBS(ML),
      .ITER_BITS(IB)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .c_val       (c_val),
      .c_rdy       (c_rdy),
      .c_last      (c_last),
      .max_iter    (max_iter),
      .limb_ind    (limb_ind),
      .cre_wr_en   (cre_wr_en),
      .cim_wr_en   (cim_wr_en),
      .z_clear     (z_clear),
      .dp_op       (dp_op),
      .dp_first    (dp_first),
      .dp_last     (dp_last),
      .diverged    (diverged),
      .res_val     (res_val),
      .res_rdy     (res_rdy),
      .res_count   (res_count),
      .res_escaped (res_escaped)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " c_rdy"}, 32'(c_rdy), 1);
      check({tag, " wr_en"}, {30'd0, cre_wr_en, cim_wr_en}, 0);
      check({tag, " z_clear"}, 32'(z_clear), 0);
      check({tag, " dp_first/last"}, {30'd0, dp_first, dp_last}, 0);
      check({tag, " res_val"}, 32'(res_val), 0);
      check({tag, " res_escaped"}, 32'(res_escaped), 0);
      check({tag, " dp_op"}, 32'(dp_op), 0);
      check({tag, " limb_ind"}, 32'(limb_ind), 0);
      check({tag, " res_count"}, 32'(res_count), 0);
   endtask

   // Drives n accepted beats; max_iter is scrambled after the first beat to prove it is latched.
   task automatic load_c(input int n, input bit with_last, input logic [IB-1:0] mi, input bit keep_val);
      for (int i = 0; i < n; i++) begin
         c_val    = 1'b1;
         c_last   = with_last && (i == n - 1);
         max_iter = (i == 0) ? mi : ~mi;
         #1;
         check("load c_rdy", 32'(c_rdy), 1);
         check("load limb_ind", 32'(limb_ind), 32'(i));
         check("load wr_en", {30'd0, cre_wr_en, cim_wr_en}, 3);
         check("load z_clear", 32'(z_clear), (i == 0) ? 1 : 0);
         check("load dp_op", 32'(dp_op), 0);
         @(posedge clock);
         #1;
      end
      c_last = 1'b0;
      if (!keep_val) c_val = 1'b0;
   endtask

   // Advances until res_val, returning the cycle index relative to the last load beat.
   task automatic wait_res(input int kstart, input int budget, output int k);
      k = kstart;
      while (res_val !== 1'b1 && k < budget) begin
         tick();
         k++;
      end
   endtask

   task automatic release_res();
      res_rdy = 1'b1;
      tick();
      res_rdy = 1'b0;
      check("release res_val", 32'(res_val), 0);
      check("release c_rdy", 32'(c_rdy), 1);
   endtask

   initial begin
      int k;
      bit seen;

      // Reset state
      reset = 1'b1;
      repeat (3) tick();
      check_reset_vals("reset");
      reset = 1'b0;
      tick();

      // A: 4 limbs, diverged at 3rd CHECK, limit 100; diverged also high in non-CHECK cycles
      load_c(4, 1'b1, 16'd100, 1'b0);
      for (int kk = 1; kk <= 27; kk++) begin
         diverged = ((kk >= 1 && kk <= 8) || (kk >= 19 && kk <= 27));
         check("A res_val low", 32'(res_val), 0);
         check("A c_rdy low", 32'(c_rdy), 0);
         if (kk <= 9) begin
            check("A dp_op", 32'(dp_op), (kk <= 4) ? 1 : (kk <= 8) ? 2 : 0);
            check("A limb_ind", 32'(limb_ind), (kk <= 8) ? 32'((kk - 1) % 4) : 0);
            check("A dp_first", 32'(dp_first), (kk <= 8 && (kk - 1) % 4 == 0) ? 1 : 0);
            check("A dp_last", 32'(dp_last), (kk <= 8 && (kk - 1) % 4 == 3) ? 1 : 0);
         end
         tick();
      end
      diverged = 1'b0;
      check("A res_val at 28", 32'(res_val), 1);
      check("A res_count", 32'(res_count), 3);
      check("A res_escaped", 32'(res_escaped), 1);

      // Backpressure: result held with a competing c beat offered
      c_val = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("BP res_val", 32'(res_val), 1);
         check("BP res_count", 32'(res_count), 3);
         check("BP res_escaped", 32'(res_escaped), 1);
         check("BP c_rdy", 32'(c_rdy), 0);
         check("BP wr_en", {30'd0, cre_wr_en, cim_wr_en}, 0);
      end
      c_val = 1'b0;
      release_res();

      // B: 2 limbs, limit 5, never diverges -> 5 iterations of 5 cycles
      load_c(2, 1'b1, 16'd5, 1'b0);
      wait_res(1, 200, k);
      check("B latency", 32'(k), 26);
      check("B res_count", 32'(res_count), 5);
      check("B res_escaped", 32'(res_escaped), 0);
      release_res();

      // C: limit 0 -> straight to DONE, no passes
      load_c(3, 1'b1, 16'd0, 1'b0);
      check("C res_val", 32'(res_val), 1);
      check("C dp_op", 32'(dp_op), 0);
      check("C res_count", 32'(res_count), 0);
      check("C res_escaped", 32'(res_escaped), 0);
      release_res();

      // D: MAX_LIMBS beats without c_last, extra beat refused
      load_c(ML, 1'b0, 16'd1, 1'b1);
      check("D c_rdy after forced last", 32'(c_rdy), 0);
      check("D wr_en after forced last", {30'd0, cre_wr_en, cim_wr_en}, 0);
      c_val = 1'b0;
      repeat (ML - 1) tick();
      check("D abs last limb", 32'(limb_ind), 32'(ML - 1));
      check("D abs dp_last", 32'(dp_last), 1);
      check("D abs dp_op", 32'(dp_op), 1);
      tick();
      check("D iter dp_op", 32'(dp_op), 2);
      check("D iter limb_ind", 32'(limb_ind), 0);
      check("D iter dp_first", 32'(dp_first), 1);
      wait_res(ML + 1, 300, k);
      check("D latency", 32'(k), 2 * ML + 2);
      check("D res_count", 32'(res_count), 1);
      release_res();

      // E: single limb, limit 3 -> 3-cycle iterations
      load_c(1, 1'b1, 16'd3, 1'b0);
      check("E abs op", 32'(dp_op), 1);
      check("E abs first/last", {30'd0, dp_first, dp_last}, 3);
      tick();
      check("E iter op", 32'(dp_op), 2);
      check("E iter first/last", {30'd0, dp_first, dp_last}, 3);
      tick();
      check("E check op", 32'(dp_op), 0);
      tick();
      check("E 2nd abs first/last", {30'd0, dp_first, dp_last}, 3);
      wait_res(4, 100, k);
      check("E latency", 32'(k), 10);
      check("E res_count", 32'(res_count), 3);
      release_res();

      // F: reset mid-ITER discards the run
      load_c(2, 1'b1, 16'd10, 1'b0);
      tick();
      tick();
      check("F in ITER", 32'(dp_op), 2);
      reset = 1'b1;
      tick();
      check_reset_vals("F reset");
      reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (res_val !== 1'b0) seen = 1'b1;
      end
      check("F no res_val after reset", 32'(seen), 0);
      check("F idle c_rdy", 32'(c_rdy), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
